// File: rtl/timer_load_ctrl_if.sv
// Keypad/counter-chain signal bundle for the microwave timer load controller.
// The master side is the keypad decoder plus counter chain; the slave side is the controller.
interface timer_load_ctrl_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       door_closed;
    logic       timer_zero;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       loadn;
    logic       count_en;
    logic       running;
    logic       done;
    logic       entry_err;

    modport master (
        output key_valid, key_code, door_closed, timer_zero,
        input  min_ones, sec_tens, sec_ones, loadn, count_en, running, done, entry_err
    );

    modport slave (
        input  key_valid, key_code, door_closed, timer_zero,
        output min_ones, sec_tens, sec_ones, loadn, count_en, running, done, entry_err
    );
endinterface

// File: rtl/timer_load_ctrl.sv
// Microwave timer load controller: gathers M:SS digits from the keypad, loads the BCD
// down-counter chain, and paces it with a 1 Hz enable through RUN/PAUSE/DONE sequencing.
module timer_load_ctrl #(
    parameter int TICK_DIV = 100
) (
    input  logic             clock,
    input  logic             clear,
    timer_load_ctrl_if.slave bus
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    localparam logic [3:0] KEY_CLR   = 4'hA;
    localparam logic [3:0] KEY_START = 4'hB;
    localparam logic [3:0] KEY_STOP  = 4'hC;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      min_q, min_d;
    logic [3:0]      tens_q, tens_d;
    logic [3:0]      ones_q, ones_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            err_q, err_d;

    function automatic logic is_digit(input logic [3:0] k);
        return (k <= 4'd9);
    endfunction

    function automatic logic [PW-1:0] presc_next(input logic [PW-1:0] p);
        return (p == PRESC_LAST) ? '0 : p + 1'b1;
    endfunction

    logic key_act;
    logic digits_zero;
    logic tick;

    assign key_act     = bus.key_valid;
    assign digits_zero = (min_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd0);
    assign tick        = (presc_q == PRESC_LAST);

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        presc_d = presc_q;
        err_d   = err_q;

        // Any accepted key clears a previous error; a rejection below re-asserts it.
        if (key_act) begin
            err_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (key_act) begin
                    if (is_digit(bus.key_code)) begin
                        if (ones_q > 4'd5) begin
                            err_d = 1'b1;
                        end else begin
                            min_d  = tens_q;
                            tens_d = ones_q;
                            ones_d = bus.key_code;
                        end
                    end else if (bus.key_code == KEY_CLR || bus.key_code == KEY_STOP) begin
                        min_d  = 4'd0;
                        tens_d = 4'd0;
                        ones_d = 4'd0;
                    end else if (bus.key_code == KEY_START) begin
                        if (digits_zero || !bus.door_closed) begin
                            err_d = 1'b1;
                        end else begin
                            state_d = S_LOAD;
                        end
                    end
                end
            end

            S_LOAD: begin
                presc_d = '0;
                state_d = S_RUN;
            end

            S_RUN: begin
                // Counter reaching zero wins over any tick, key or door event.
                if (bus.timer_zero) begin
                    state_d = S_DONE;
                end else if ((key_act && bus.key_code == KEY_STOP) || !bus.door_closed) begin
                    state_d = S_PAUSE;
                end else begin
                    presc_d = presc_next(presc_q);
                end
            end

            S_PAUSE: begin
                if (key_act) begin
                    if (bus.key_code == KEY_START) begin
                        if (bus.door_closed) begin
                            state_d = S_RUN;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (bus.key_code == KEY_STOP || bus.key_code == KEY_CLR) begin
                        state_d = S_IDLE;
                        min_d   = 4'd0;
                        tens_d  = 4'd0;
                        ones_d  = 4'd0;
                    end
                end
            end

            S_DONE: begin
                if (key_act) begin
                    state_d = S_IDLE;
                    if (is_digit(bus.key_code)) begin
                        min_d  = 4'd0;
                        tens_d = 4'd0;
                        ones_d = bus.key_code;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= S_IDLE;
            min_q   <= 4'd0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            presc_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            presc_q <= presc_d;
            err_q   <= err_d;
        end
    end

    // Load pulse doubles as an enable because the counters only load while enabled.
    assign bus.loadn     = (state_q != S_LOAD);
    assign bus.count_en  = (state_q == S_LOAD) ||
                           ((state_q == S_RUN) && tick && !bus.timer_zero);
    assign bus.running   = (state_q == S_RUN);
    assign bus.done      = (state_q == S_DONE);
    assign bus.entry_err = err_q;
    assign bus.min_ones  = min_q;
    assign bus.sec_tens  = tens_q;
    assign bus.sec_ones  = ones_q;

endmodule

// File: tb/tb_timer_load_ctrl.sv
// Self-checking bench for timer_load_ctrl: directed scenarios plus a randomized run
// compared every cycle against an arithmetic model of the keypad/timer rules.
module tb_timer_load_ctrl;

    localparam int TICK_DIV = 4;

    localparam logic [3:0] K_CLR   = 4'hA;
    localparam logic [3:0] K_START = 4'hB;
    localparam logic [3:0] K_STOP  = 4'hC;

    localparam int M_IDLE  = 0;
    localparam int M_LOAD  = 1;
    localparam int M_RUN   = 2;
    localparam int M_PAUSE = 3;
    localparam int M_DONE  = 4;

    logic clock = 1'b0;
    logic clear;
    always #5 clock = ~clock;

    timer_load_ctrl_if bus ();

    timer_load_ctrl #(.TICK_DIV(TICK_DIV)) dut (
        .clock(clock),
        .clear(clear),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: entry held as a 3-digit decimal number, run time as elapsed RUN cycles.
    int          m_mode  = M_IDLE;
    int          m_entry = 0;
    int          m_ticks = 0;
    logic        m_err   = 1'b0;
    logic [16:0] m_exp;

    function automatic logic [16:0] m_expect(input logic tz);
        logic [3:0] mn, st, so;
        logic       ce;
        mn = 4'(m_entry / 100);
        st = 4'((m_entry / 10) % 10);
        so = 4'(m_entry % 10);
        ce = (m_mode == M_LOAD) ||
             (m_mode == M_RUN && (m_ticks % TICK_DIV) == TICK_DIV - 1 && !tz);
        return {mn, st, so, (m_mode != M_LOAD), ce, (m_mode == M_RUN), (m_mode == M_DONE), m_err};
    endfunction

    task automatic model_step(input logic clr, input logic kv, input logic [3:0] kc,
                              input logic door, input logic tz);
        logic digit;
        digit = (kc <= 4'd9);
        if (clr) begin
            m_mode = M_IDLE; m_entry = 0; m_ticks = 0; m_err = 1'b0;
            return;
        end
        if (kv) m_err = 1'b0;
        case (m_mode)
            M_IDLE: if (kv) begin
                if (digit) begin
                    if ((m_entry % 10) > 5) m_err = 1'b1;
                    else m_entry = (m_entry * 10 + int'(kc)) % 1000;
                end else if (kc == K_CLR || kc == K_STOP) begin
                    m_entry = 0;
                end else if (kc == K_START) begin
                    if (m_entry == 0 || !door) m_err = 1'b1;
                    else m_mode = M_LOAD;
                end
            end
            M_LOAD: begin
                m_ticks = 0;
                m_mode  = M_RUN;
            end
            M_RUN: begin
                if (tz) m_mode = M_DONE;
                else if ((kv && kc == K_STOP) || !door) m_mode = M_PAUSE;
                else m_ticks++;
            end
            M_PAUSE: if (kv) begin
                if (kc == K_START) begin
                    if (door) m_mode = M_RUN;
                    else m_err = 1'b1;
                end else if (kc == K_STOP || kc == K_CLR) begin
                    m_mode = M_IDLE; m_entry = 0;
                end
            end
            M_DONE: if (kv) begin
                m_mode = M_IDLE;
                if (digit) m_entry = int'(kc);
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    // One clock cycle: apply inputs after the falling edge, sample, and advance the model.
    task automatic drive(input logic clr, input logic kv, input logic [3:0] kc,
                         input logic door, input logic tz);
        @(negedge clock);
        clear           = clr;
        bus.key_valid   = kv;
        bus.key_code    = kc;
        bus.door_closed = door;
        bus.timer_zero  = tz;
        #1;
        m_exp = m_expect(tz);
        model_step(clr, kv, kc, door, tz);
    endtask

    task automatic idle(input logic door);
        drive(1'b0, 1'b0, 4'h0, door, 1'b0);
    endtask

    task automatic key(input logic [3:0] kc, input logic door);
        drive(1'b0, 1'b1, kc, door, 1'b0);
    endtask

    task automatic test_reset;
        key(4'd4, 1'b1);
        drive(1'b1, 1'b1, 4'd5, 1'b1, 1'b0);
        idle(1'b1);
        n_checks++;
        if ({bus.min_ones, bus.sec_tens, bus.sec_ones} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_digits got %h want 000", {bus.min_ones, bus.sec_tens, bus.sec_ones});
        end
        n_checks++;
        if ({bus.loadn, bus.count_en} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_load got loadn/count_en=%b want 10", {bus.loadn, bus.count_en});
        end
        n_checks++;
        if ({bus.running, bus.done, bus.entry_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_status got %b want 000", {bus.running, bus.done, bus.entry_err});
        end
    endtask

    task automatic test_entry_load;
        drive(1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
        key(4'd1, 1'b1);
        key(4'd3, 1'b1);
        key(4'd0, 1'b1);
        key(K_START, 1'b1);
        n_checks++;
        if ({bus.min_ones, bus.sec_tens, bus.sec_ones} !== 12'h130) begin
            n_fail++;
            $display("FAIL entry_digits got %h want 130", {bus.min_ones, bus.sec_tens, bus.sec_ones});
        end
        idle(1'b1);
        n_checks++;
        if ({bus.loadn, bus.count_en} !== 2'b01) begin
            n_fail++;
            $display("FAIL load_pulse got loadn/count_en=%b want 01", {bus.loadn, bus.count_en});
        end
        idle(1'b1);
        n_checks++;
        if ({bus.loadn, bus.count_en, bus.running} !== 3'b101) begin
            n_fail++;
            $display("FAIL run_entry got loadn/count_en/running=%b want 101",
                     {bus.loadn, bus.count_en, bus.running});
        end
    endtask

    task automatic test_digit_reject;
        drive(1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
        key(4'd7, 1'b1);
        key(4'd0, 1'b1);
        idle(1'b1);
        n_checks++;
        if ({bus.entry_err, bus.min_ones, bus.sec_tens, bus.sec_ones} !== 13'h1007) begin
            n_fail++;
            $display("FAIL digit_reject got err=%b digits=%h want err=1 digits=007", bus.entry_err,
                     {bus.min_ones, bus.sec_tens, bus.sec_ones});
        end
        key(4'hE, 1'b1);
        idle(1'b1);
        n_checks++;
        if ({bus.entry_err, bus.min_ones, bus.sec_tens, bus.sec_ones} !== 13'h0007) begin
            n_fail++;
            $display("FAIL err_clear got err=%b digits=%h want err=0 digits=007", bus.entry_err,
                     {bus.min_ones, bus.sec_tens, bus.sec_ones});
        end
    endtask

    task automatic test_start_reject;
        drive(1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
        key(K_START, 1'b1);
        idle(1'b1);
        n_checks++;
        if ({bus.entry_err, bus.loadn, bus.running} !== 3'b110) begin
            n_fail++;
            $display("FAIL start_zero got err/loadn/running=%b want 110",
                     {bus.entry_err, bus.loadn, bus.running});
        end
        key(4'd5, 1'b1);
        key(K_START, 1'b0);
        idle(1'b0);
        n_checks++;
        if ({bus.entry_err, bus.loadn, bus.running} !== 3'b110) begin
            n_fail++;
            $display("FAIL start_door_open got err/loadn/running=%b want 110",
                     {bus.entry_err, bus.loadn, bus.running});
        end
        idle(1'b1);
        n_checks++;
        if ({bus.loadn, bus.running, bus.sec_ones} !== 6'b10_0101) begin
            n_fail++;
            $display("FAIL start_door_open_stay got loadn/running=%b ones=%h want 10 ones=5",
                     {bus.loadn, bus.running}, bus.sec_ones);
        end
    endtask

    task automatic test_tick_done;
        drive(1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
        key(4'd5, 1'b1);
        key(K_START, 1'b1);
        idle(1'b1);
        for (int i = 0; i < 12; i++) begin
            idle(1'b1);
            n_checks++;
            if (bus.count_en !== ((i % TICK_DIV) == TICK_DIV - 1)) begin
                n_fail++;
                $display("FAIL tick_cycle%0d got count_en=%b want %b", i, bus.count_en,
                         ((i % TICK_DIV) == TICK_DIV - 1));
            end
        end
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
        n_checks++;
        if (bus.count_en !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_on_tick got count_en=%b want 0", bus.count_en);
        end
        idle(1'b1);
        n_checks++;
        if ({bus.done, bus.running, bus.count_en} !== 3'b100) begin
            n_fail++;
            $display("FAIL done_state got done/running/count_en=%b want 100",
                     {bus.done, bus.running, bus.count_en});
        end
        key(4'd7, 1'b0);
        idle(1'b1);
        n_checks++;
        if ({bus.done, bus.min_ones, bus.sec_tens, bus.sec_ones} !== 13'h0007) begin
            n_fail++;
            $display("FAIL done_digit got done=%b digits=%h want done=0 digits=007", bus.done,
                     {bus.min_ones, bus.sec_tens, bus.sec_ones});
        end
    endtask

    task automatic test_door_pause;
        logic bad;
        drive(1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
        key(4'd5, 1'b1);
        key(K_START, 1'b1);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            idle(1'b0);
            if ({bus.count_en, bus.running, bus.loadn} !== 3'b001) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL pause_quiet got count_en/running/loadn=%b want 001 throughout",
                     {bus.count_en, bus.running, bus.loadn});
        end
        key(K_START, 1'b1);
        idle(1'b1);
        n_checks++;
        if ({bus.running, bus.count_en, bus.loadn} !== 3'b101) begin
            n_fail++;
            $display("FAIL resume got running/count_en/loadn=%b want 101",
                     {bus.running, bus.count_en, bus.loadn});
        end
        idle(1'b1);
        n_checks++;
        if ({bus.count_en, bus.loadn} !== 2'b11) begin
            n_fail++;
            $display("FAIL resume_tick got count_en/loadn=%b want 11", {bus.count_en, bus.loadn});
        end
    endtask

    task automatic test_clear_stop;
        drive(1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
        key(4'd2, 1'b1);
        key(K_START, 1'b1);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        drive(1'b1, 1'b1, K_STOP, 1'b1, 1'b0);
        idle(1'b1);
        n_checks++;
        if ({bus.min_ones, bus.sec_tens, bus.sec_ones, bus.loadn, bus.count_en,
             bus.running, bus.done, bus.entry_err} !== {12'h000, 5'b10000}) begin
            n_fail++;
            $display("FAIL clear_with_stop got %h want %h",
                     {bus.min_ones, bus.sec_tens, bus.sec_ones, bus.loadn, bus.count_en,
                      bus.running, bus.done, bus.entry_err}, {12'h000, 5'b10000});
        end
    endtask

    task automatic test_random;
        logic        clr, kv, door, tz;
        logic [3:0]  kc;
        logic [16:0] obs;
        drive(1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            clr  = ($urandom_range(0, 199) == 0);
            kv   = ($urandom_range(0, 2) == 0);
            kc   = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) kc = K_START;
            door = ($urandom_range(0, 9) != 0);
            tz   = ($urandom_range(0, 29) == 0);
            drive(clr, kv, kc, door, tz);
            obs = {bus.min_ones, bus.sec_tens, bus.sec_ones, bus.loadn, bus.count_en,
                   bus.running, bus.done, bus.entry_err};
            n_checks++;
            if (obs !== m_exp) begin
                n_fail++;
                $display("FAIL random_cycle%0d got %h want %h", i, obs, m_exp);
            end
        end
    endtask

    initial begin
        clear           = 1'b1;
        bus.key_valid   = 1'b0;
        bus.key_code    = 4'h0;
        bus.door_closed = 1'b1;
        bus.timer_zero  = 1'b0;
        test_reset();
        test_entry_load();
        test_digit_reject();
        test_start_reject();
        test_tick_done();
        test_door_pause();
        test_clear_stop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
